branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-side counterpart of the branch resolution logic: predicts branch direction and target for the IF-stage PC, then consumes the resolved outcome (taken flag, target) from the resolution stage to train itself.
- Direct-mapped BTB with a 2-bit saturating counter per entry.
- Raises a mispredict/redirect to the PC mux.
- Keeps branch and mispredict statistics counters.

Parameters:
- ENTRIES, 16, number of table entries (power of two).
- IDX_W, 4, log2(ENTRIES); index = pc[IDX_W+1:2].
- TAG_W, 26, tag width = 30-IDX_W; tag = pc[31:IDX_W+2].

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous reset, active-high
- if_pc_i  in  32  PC being fetched
- pred_taken_o  out  1  prediction for if_pc_i: taken
- pred_target_o  out  32  predicted next PC for if_pc_i
- upd_valid_i  in  1  a branch resolved this cycle
- upd_pc_i  in  32  PC of the resolved branch
- upd_taken_i  in  1  resolved direction (branch enable from resolution logic)
- upd_target_i  in  32  resolved branch target
- upd_pred_taken_i  in  1  prediction made for this branch at fetch (piped down)
- upd_pred_target_i  in  32  predicted next PC made at fetch (piped down)
- mispredict_o  out  1  resolved outcome differs from prediction
- redirect_pc_o  out  32  correct next PC when mispredict_o=1
- branch_cnt_o  out  32  resolved-branch count
- mispred_cnt_o  out  32  mispredict count

Behaviour:
- Reset (async, rst_i=1):
  - All entry valid bits = 0.
  - All counters = 2'b01 (weakly not-taken).
  - Tags and targets = 0.
  - branch_cnt_o = mispred_cnt_o = 0.
  - With all entries invalid, pred_taken_o=0 and pred_target_o=if_pc_i+4.
  - Reset mid-update discards that update.
- Lookup (combinational, 0-cycle):
  - hit = valid[idx] && tag[idx]==tag(if_pc_i).
  - pred_taken_o = hit && ctr[idx][1].
  - pred_target_o = pred_taken_o ? target[idx] : if_pc_i+4 (32-bit wrap).
- Mispredict (combinational from upd_* inputs):
  - mispredict_o = upd_valid_i && (upd_pred_taken_i != upd_taken_i || (upd_taken_i && upd_pred_target_i != upd_target_i)).
  - redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i+4. No delay slot.
  - mispredict_o=0 whenever upd_valid_i=0; redirect_pc_o is don't-care then but still driven by the same formula.
- Training (rising edge, upd_valid_i=1), entry u = index of upd_pc_i:
  - Hit, taken: ctr saturating +1 (11 stays 11); target[u] <= upd_target_i.
  - Hit, not taken: ctr saturating -1 (00 stays 00); target unchanged.
  - Miss, taken: allocate. valid=1, tag=tag(upd_pc_i), target=upd_target_i, ctr=2'b10 (weakly taken). Overwrites any aliasing entry.
  - Miss, not taken: no change.
- Statistics (rising edge):
  - branch_cnt_o += 1 when upd_valid_i.
  - mispred_cnt_o += 1 when mispredict_o.
  - Both wrap modulo 2^32.
- Simultaneous lookup and update of the same index: lookup returns pre-update contents; no bypass. The new state is visible the next cycle.
- Single write port; at most one update per cycle.

Decomposition:
- Shared package:
  - Counter encodings: CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11.
  - CTR_RESET=CTR_WNT and CTR_ALLOC=CTR_WT.
  - PC_STEP=32'd4.
- One sub-module: bp_sat_ctr. Purely combinational next-state for the 2-bit counter (inputs: cur, taken; output: next), instantiated once on the update path.
- Table arrays and statistics counters live in branch_predictor.

Test Plan:
- Reset then lookup: if_pc_i=32'h0000_0040 -> pred_taken_o=0, pred_target_o=32'h0000_0044; both stat counters 0.
- Allocate on taken miss:
  - Stimulus: update pc=32'h40, taken=1, target=32'h100, pred_taken=0.
  - Same cycle: mispredict_o=1, redirect_pc_o=32'h100.
  - Next cycle, lookup 32'h40: pred_taken_o=1, pred_target_o=32'h100.
  - Counts: branch_cnt_o=1, mispred_cnt_o=1.
- Saturation and hysteresis:
  - From ctr=10, three taken updates -> ctr=11.
  - Then one not-taken -> still predicts taken.
  - Second not-taken -> pred_taken_o=0.
  - Four more not-taken -> ctr=00, no underflow.
- Alias eviction:
  - Entry for 32'h40 valid; taken update for 32'h80 (same index when IDX_W=4 gives a different tag).
  - Lookup 32'h40 -> miss, target=32'h44.
  - Lookup 32'h80 -> hit.
- Target mismatch:
  - pred_taken=1, pred_target=32'h100, resolved taken to 32'h200.
  - mispredict_o=1, redirect_pc_o=32'h200; entry target updated to 32'h200.
- Async reset mid-stream: assert rst_i between clock edges while upd_valid_i=1 -> counters 0 and all lookups miss immediately; the in-flight update is not applied.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared counter encodings and PC constants for the branch predictor
package branch_predictor_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    // New entries start weakly taken: the allocating branch was just taken.
    localparam ctr_t CTR_RESET = CTR_WNT;
    localparam ctr_t CTR_ALLOC = CTR_WT;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/branch_predictor_sat_ctr.sv
// rtl/branch_predictor_sat_ctr.sv - 2-bit saturating direction counter next-state logic
module bp_sat_ctr
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cur_i,
    input  logic       taken_i,
    output logic [1:0] next_o
);

    // Step toward the resolved direction, holding at the extremes.
    always_comb begin
        next_o = cur_i;
        if (taken_i) begin
            if (cur_i != CTR_ST) begin
                next_o = cur_i + 2'd1;
            end
        end else begin
            if (cur_i != CTR_SNT) begin
                next_o = cur_i - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters, mispredict detect and statistics
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int TAG_W   = 26
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] if_pc_i,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic [31:0] upd_target_i,
    input  logic        upd_pred_taken_i,
    input  logic [31:0] upd_pred_target_i,
    output logic        mispredict_o,
    output logic [31:0] redirect_pc_o,
    output logic [31:0] branch_cnt_o,
    output logic [31:0] mispred_cnt_o
);

    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [31:0]      target_d [ENTRIES];
    ctr_t             ctr_q    [ENTRIES];
    ctr_t             ctr_d    [ENTRIES];

    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    ctr_t             up_ctr_next;

    // Byte-offset bits never select anything; word-aligned PCs only.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc_i[1:0], upd_pc_i[1:0]};

    assign lk_idx = if_pc_i[IDX_W+1:2];
    assign lk_tag = if_pc_i[31:IDX_W+2];
    assign up_idx = upd_pc_i[IDX_W+1:2];
    assign up_tag = upd_pc_i[31:IDX_W+2];

    // Fetch-side lookup reads the registered table only, so same-cycle updates are not bypassed.
    always_comb begin
        lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken_o  = lk_hit && ctr_q[lk_idx][1];
        pred_target_o = pred_taken_o ? target_q[lk_idx] : (if_pc_i + PC_STEP);
    end

    // Compare the resolved outcome with what fetch predicted and compute the correct next PC.
    always_comb begin
        mispredict_o  = upd_valid_i &&
                        ((upd_pred_taken_i != upd_taken_i) ||
                         (upd_taken_i && (upd_pred_target_i != upd_target_i)));
        redirect_pc_o = upd_taken_i ? upd_target_i : (upd_pc_i + PC_STEP);
    end

    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    bp_sat_ctr u_sat_ctr (
        .cur_i   (ctr_q[up_idx]),
        .taken_i (upd_taken_i),
        .next_o  (up_ctr_next)
    );

    // Training: train the counter on a hit, allocate on a taken miss, ignore a not-taken miss.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (upd_valid_i) begin
            if (up_hit) begin
                ctr_d[up_idx] = up_ctr_next;
                if (upd_taken_i) begin
                    target_d[up_idx] = upd_target_i;
                end
            end else if (upd_taken_i) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = upd_target_i;
                ctr_d[up_idx]    = CTR_ALLOC;
            end
        end
    end

    // Statistics advance once per resolved branch and once per mispredict, wrapping naturally.
    always_comb begin
        branch_cnt_d  = branch_cnt_q + (upd_valid_i ? 32'd1 : 32'd0);
        mispred_cnt_d = mispred_cnt_q + (mispredict_o ? 32'd1 : 32'd0);
    end

    // Table and statistics registers; reset clears the table to invalid, weakly not-taken.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RESET;
            end
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            valid_q       <= valid_d;
            tag_q         <= tag_d;
            target_q      <= target_d;
            ctr_q         <= ctr_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor against a behavioural model
module tb_branch_predictor;

    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] if_pc_i = '0;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        upd_valid_i = 1'b0;
    logic [31:0] upd_pc_i = '0;
    logic        upd_taken_i = 1'b0;
    logic [31:0] upd_target_i = '0;
    logic        upd_pred_taken_i = 1'b0;
    logic [31:0] upd_pred_target_i = '0;
    logic        mispredict_o;
    logic [31:0] redirect_pc_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispred_cnt_o;

    always #5 clk_i = ~clk_i;

    branch_predictor dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .if_pc_i           (if_pc_i),
        .pred_taken_o      (pred_taken_o),
        .pred_target_o     (pred_target_o),
        .upd_valid_i       (upd_valid_i),
        .upd_pc_i          (upd_pc_i),
        .upd_taken_i       (upd_taken_i),
        .upd_target_i      (upd_target_i),
        .upd_pred_taken_i  (upd_pred_taken_i),
        .upd_pred_target_i (upd_pred_target_i),
        .mispredict_o      (mispredict_o),
        .redirect_pc_o     (redirect_pc_o),
        .branch_cnt_o      (branch_cnt_o),
        .mispred_cnt_o     (mispred_cnt_o)
    );

    // Reference model: table of entries with an integer confidence 0..3.
    bit          m_valid  [ENTRIES];
    logic [31:0] m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_conf   [ENTRIES];
    logic [31:0] m_branches;
    logic [31:0] m_mispreds;

    int checks = 0;
    int errors = 0;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic logic [31:0] m_tag_of(input logic [31:0] pc);
        return pc >> (IDX_W + 2);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tag_of(pc));
    endfunction

    function automatic bit m_pred_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_conf[m_idx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_target(input logic [31:0] pc);
        return m_pred_taken(pc) ? m_target[m_idx(pc)] : pc + 32'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = '0;
            m_target[i] = '0;
            m_conf[i]   = 1;
        end
        m_branches = '0;
        m_mispreds = '0;
    endtask

    task automatic model_train(input logic [31:0] pc, input bit t, input logic [31:0] tgt, input bit mis);
        int u;
        u = m_idx(pc);
        m_branches = m_branches + 32'd1;
        if (mis) m_mispreds = m_mispreds + 32'd1;
        if (m_hit(pc)) begin
            if (t) begin
                m_conf[u]   = (m_conf[u] == 3) ? 3 : m_conf[u] + 1;
                m_target[u] = tgt;
            end else begin
                m_conf[u] = (m_conf[u] == 0) ? 0 : m_conf[u] - 1;
            end
        end else if (t) begin
            m_valid[u]  = 1'b1;
            m_tag[u]    = m_tag_of(pc);
            m_target[u] = tgt;
            m_conf[u]   = 2;
        end
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // One clock: drive inputs, check combinational outputs at the falling edge, train the model at the rising edge.
    task automatic cycle(input bit v, input logic [31:0] pc, input bit t, input logic [31:0] tgt,
                         input bit pt, input logic [31:0] ptgt, input logic [31:0] look);
        bit mis;
        upd_valid_i       = v;
        upd_pc_i          = pc;
        upd_taken_i       = t;
        upd_target_i      = tgt;
        upd_pred_taken_i  = pt;
        upd_pred_target_i = ptgt;
        if_pc_i           = look;
        @(negedge clk_i);
        mis = v && ((pt != t) || (t && (ptgt != tgt)));
        check("mispredict", {31'b0, mispredict_o}, {31'b0, mis});
        check("redirect_pc", redirect_pc_o, t ? tgt : pc + 32'd4);
        check("pred_taken", {31'b0, pred_taken_o}, {31'b0, m_pred_taken(look)});
        check("pred_target", pred_target_o, m_pred_target(look));
        check("branch_cnt", branch_cnt_o, m_branches);
        check("mispred_cnt", mispred_cnt_o, m_mispreds);
        @(posedge clk_i);
        if (v) model_train(pc, t, tgt, mis);
        #1;
        upd_valid_i = 1'b0;
    endtask

    // Update whose fetch-time prediction comes from the model, as a real pipeline would supply.
    task automatic train(input logic [31:0] pc, input bit t, input logic [31:0] tgt);
        cycle(1'b1, pc, t, tgt, m_pred_taken(pc), m_pred_target(pc), pc);
    endtask

    task automatic look(input logic [31:0] pc);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, pc);
    endtask

    initial begin
        logic [31:0] r_pc;
        logic [31:0] r_look;
        logic [31:0] r_tgt;
        bit          r_t;
        bit          r_v;
        bit          r_pt;
        logic [31:0] r_ptgt;

        model_reset();

        // Reset state, observed while reset is held.
        if_pc_i = 32'h0000_0040;
        #3;
        check("rst_pred_taken", {31'b0, pred_taken_o}, 32'd0);
        check("rst_pred_target", pred_target_o, 32'h0000_0044);
        check("rst_branch_cnt", branch_cnt_o, 32'd0);
        check("rst_mispred_cnt", mispred_cnt_o, 32'd0);
        #9;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        look(32'h0000_0040);

        // Allocate on a taken miss.
        cycle(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 32'h40);
        look(32'h40);
        check("alloc_pred_taken", {31'b0, pred_taken_o}, 32'd1);
        check("alloc_pred_target", pred_target_o, 32'h100);
        check("alloc_branch_cnt", branch_cnt_o, 32'd1);
        check("alloc_mispred_cnt", mispred_cnt_o, 32'd1);

        // Saturate upward, then walk down past hysteresis and hold at the floor.
        for (int i = 0; i < 3; i++) train(32'h40, 1'b1, 32'h100);
        train(32'h40, 1'b0, 32'h100);
        look(32'h40);
        check("hyst_still_taken", {31'b0, pred_taken_o}, 32'd1);
        train(32'h40, 1'b0, 32'h100);
        look(32'h40);
        check("hyst_now_not_taken", {31'b0, pred_taken_o}, 32'd0);
        for (int i = 0; i < 4; i++) train(32'h40, 1'b0, 32'h100);
        train(32'h40, 1'b1, 32'h100);
        look(32'h40);
        check("floor_one_taken", {31'b0, pred_taken_o}, 32'd0);
        train(32'h40, 1'b1, 32'h100);
        look(32'h40);
        check("floor_two_taken", {31'b0, pred_taken_o}, 32'd1);

        // Alias eviction: 0x80 shares the index of 0x40 with a different tag.
        train(32'h80, 1'b1, 32'h300);
        look(32'h40);
        check("alias_old_miss", pred_target_o, 32'h44);
        look(32'h80);
        check("alias_new_hit", pred_target_o, 32'h300);

        // Target mismatch on a correctly predicted direction.
        train(32'h80, 1'b1, 32'h100);
        cycle(1'b1, 32'h80, 1'b1, 32'h200, 1'b1, 32'h100, 32'h80);
        look(32'h80);
        check("retarget", pred_target_o, 32'h200);
        cycle(1'b1, 32'h80, 1'b1, 32'h200, 1'b1, 32'h200, 32'h80);
        cycle(1'b1, 32'h80, 1'b0, 32'h200, 1'b1, 32'h200, 32'h80);

        // Fall-through wraps at the top of the address space.
        look(32'hFFFF_FFFC);
        check("wrap_target", pred_target_o, 32'h0000_0000);

        // Randomized traffic over a small PC set so hits, aliases and same-cycle lookups are frequent.
        for (int n = 0; n < 400; n++) begin
            r_pc   = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
            r_look = ($urandom_range(0, 1) == 1) ? r_pc
                     : ((32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2));
            r_tgt  = 32'($urandom_range(0, 7)) << 8;
            r_t    = 1'($urandom_range(0, 1));
            r_v    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) begin
                r_pt   = m_pred_taken(r_pc);
                r_ptgt = m_pred_target(r_pc);
            end else begin
                r_pt   = 1'($urandom_range(0, 1));
                r_ptgt = 32'($urandom_range(0, 7)) << 8;
            end
            cycle(r_v, r_pc, r_t, r_tgt, r_pt, r_ptgt, r_look);
        end

        // Async reset mid-cycle with an update in flight.
        train(32'h1C4, 1'b1, 32'h500);
        upd_valid_i       = 1'b1;
        upd_pc_i          = 32'h2C4;
        upd_taken_i       = 1'b1;
        upd_target_i      = 32'h600;
        upd_pred_taken_i  = 1'b0;
        upd_pred_target_i = 32'h2C8;
        if_pc_i           = 32'h1C4;
        #2;
        rst_i = 1'b1;
        #1;
        model_reset();
        check("arst_branch_cnt", branch_cnt_o, 32'd0);
        check("arst_mispred_cnt", mispred_cnt_o, 32'd0);
        check("arst_lookup_taken", {31'b0, pred_taken_o}, 32'd0);
        check("arst_lookup_target", pred_target_o, 32'h1C8);
        @(posedge clk_i);
        #1;
        upd_valid_i = 1'b0;
        #2;
        rst_i = 1'b0;
        look(32'h2C4);
        check("arst_dropped_update", pred_target_o, 32'h2C8);
        look(32'h1C4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
